// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - MIPS decode stage with EX/MEM forwarding, load-use stall and ID/EX register
module id_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3,
   parameter int STALL_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_valid_in,
   input  logic [31:0]         inst_in,
   output logic                id_ready_out,
   output logic [RADDR_W-1:0]  rf_rd_addr1,
   output logic [RADDR_W-1:0]  rf_rd_addr2,
   output logic                rf_rd_en1,
   output logic                rf_rd_en2,
   input  logic [DATA_W-1:0]   rf_rd_data1,
   input  logic [DATA_W-1:0]   rf_rd_data2,
   input  logic                ex_fwd_en,
   input  logic [RADDR_W-1:0]  ex_fwd_addr,
   input  logic [DATA_W-1:0]   ex_fwd_data,
   input  logic                mem_fwd_en,
   input  logic [RADDR_W-1:0]  mem_fwd_addr,
   input  logic [DATA_W-1:0]   mem_fwd_data,
   input  logic                ex_ready_in,
   output logic                idex_valid,
   output logic [ALUOP_W-1:0]  idex_aluop,
   output logic [ALUSEL_W-1:0] idex_alusel,
   output logic [DATA_W-1:0]   idex_op1,
   output logic [DATA_W-1:0]   idex_op2,
   output logic [RADDR_W-1:0]  idex_wr_addr,
   output logic                idex_wr_en,
   output logic                idex_invalid,
   output logic [STALL_W-1:0]  stall_cnt
);

   localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(8);

   localparam logic [ALUSEL_W-1:0] SEL_NOP   = ALUSEL_W'(0);
   localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(1);
   localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(2);
   localparam logic [ALUSEL_W-1:0] SEL_LOAD  = ALUSEL_W'(3);

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_XORI  = 6'h0E;
   localparam logic [5:0] OPC_LUI   = 6'h0F;
   localparam logic [5:0] OPC_LW    = 6'h23;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;

   logic [5:0]          opcode;
   logic [5:0]          funct;
   logic [RADDR_W-1:0]  rs;
   logic [RADDR_W-1:0]  rt;
   logic [RADDR_W-1:0]  rd;
   logic [4:0]          shamt;
   logic [15:0]         imm;

   logic [ALUOP_W-1:0]  dec_aluop;
   logic [ALUSEL_W-1:0] dec_alusel;
   logic [RADDR_W-1:0]  dec_wr_addr;
   logic                dec_writes;
   logic                dec_wr_en;
   logic                dec_invalid;
   logic                dec_rd_en1;
   logic                dec_rd_en2;
   logic [DATA_W-1:0]   dec_imm1;
   logic [DATA_W-1:0]   dec_imm2;
   logic [DATA_W-1:0]   dec_op1;
   logic [DATA_W-1:0]   dec_op2;

   logic                advance;
   logic                hazard;
   logic                hit1;
   logic                hit2;

   assign opcode = inst_in[31:26];
   assign funct  = inst_in[5:0];
   assign rs     = RADDR_W'(inst_in[25:21]);
   assign rt     = RADDR_W'(inst_in[20:16]);
   assign rd     = RADDR_W'(inst_in[15:11]);
   assign shamt  = inst_in[10:6];
   assign imm    = inst_in[15:0];

   always_comb begin
      dec_aluop   = ALU_NOP;
      dec_alusel  = SEL_NOP;
      dec_wr_addr = '0;
      dec_writes  = 1'b0;
      dec_invalid = 1'b0;
      dec_rd_en1  = 1'b0;
      dec_rd_en2  = 1'b0;
      dec_imm1    = '0;
      dec_imm2    = '0;
      case (opcode)
         OPC_ORI, OPC_ANDI, OPC_XORI: begin
            dec_aluop   = (opcode == OPC_ORI)  ? ALU_OR :
                          (opcode == OPC_ANDI) ? ALU_AND : ALU_XOR;
            dec_alusel  = SEL_LOGIC;
            dec_rd_en1  = 1'b1;
            dec_imm2    = DATA_W'(imm);
            dec_wr_addr = rt;
            dec_writes  = 1'b1;
         end
         OPC_LUI: begin
            dec_aluop   = ALU_OR;
            dec_alusel  = SEL_LOGIC;
            dec_imm2    = DATA_W'({imm, 16'h0000});
            dec_wr_addr = rt;
            dec_writes  = 1'b1;
         end
         OPC_LW: begin
            dec_aluop   = ALU_ADD;
            dec_alusel  = SEL_LOAD;
            dec_rd_en1  = 1'b1;
            dec_imm2    = DATA_W'($signed(imm));
            dec_wr_addr = rt;
            dec_writes  = 1'b1;
         end
         OPC_RTYPE: begin
            case (funct)
               FN_OR, FN_AND, FN_XOR, FN_NOR: begin
                  dec_aluop   = (funct == FN_OR)  ? ALU_OR  :
                                (funct == FN_AND) ? ALU_AND :
                                (funct == FN_XOR) ? ALU_XOR : ALU_NOR;
                  dec_alusel  = SEL_LOGIC;
                  dec_rd_en1  = 1'b1;
                  dec_rd_en2  = 1'b1;
                  dec_wr_addr = rd;
                  dec_writes  = 1'b1;
               end
               FN_SLL, FN_SRL, FN_SRA: begin
                  dec_aluop   = (funct == FN_SLL) ? ALU_SLL :
                                (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                  dec_alusel  = SEL_SHIFT;
                  dec_rd_en2  = 1'b1;
                  dec_imm1    = DATA_W'(shamt);
                  dec_wr_addr = rd;
                  dec_writes  = 1'b1;
               end
               default: dec_invalid = 1'b1;
            endcase
         end
         default: dec_invalid = 1'b1;
      endcase
   end

   // Writes to $0 are architecturally discarded, so never advertise them downstream.
   assign dec_wr_en = dec_writes && (dec_wr_addr != '0);

   assign rf_rd_addr1 = rs;
   assign rf_rd_addr2 = rt;
   assign rf_rd_en1   = dec_rd_en1;
   assign rf_rd_en2   = dec_rd_en2;

   function automatic logic [DATA_W-1:0] resolve(
      input logic                en,
      input logic [RADDR_W-1:0]  addr,
      input logic [DATA_W-1:0]   rf_data,
      input logic [DATA_W-1:0]   imm_val,
      input logic                ex_en,
      input logic [RADDR_W-1:0]  ex_addr,
      input logic [DATA_W-1:0]   ex_data,
      input logic                mem_en,
      input logic [RADDR_W-1:0]  mem_addr,
      input logic [DATA_W-1:0]   mem_data
   );
      if (!en)                             return imm_val;
      else if (addr == '0)                 return '0;
      else if (ex_en && ex_addr == addr)   return ex_data;
      else if (mem_en && mem_addr == addr) return mem_data;
      else                                 return rf_data;
   endfunction

   // The younger EX result takes priority over MEM when both target the same register.
   always_comb begin
      dec_op1 = resolve(dec_rd_en1, rs, rf_rd_data1, dec_imm1,
                        ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                        mem_fwd_en, mem_fwd_addr, mem_fwd_data);
      dec_op2 = resolve(dec_rd_en2, rt, rf_rd_data2, dec_imm2,
                        ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                        mem_fwd_en, mem_fwd_addr, mem_fwd_data);
   end

   assign hit1 = dec_rd_en1 && (rs != '0) && (rs == idex_wr_addr);
   assign hit2 = dec_rd_en2 && (rt != '0) && (rt == idex_wr_addr);

   // Load data only exists after MEM, so a dependent instruction must wait one cycle.
   assign hazard = idex_valid && (idex_alusel == SEL_LOAD) && idex_wr_en &&
                   if_valid_in && (hit1 || hit2);

   assign advance      = !idex_valid || ex_ready_in;
   assign id_ready_out = advance && !hazard;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idex_valid   <= 1'b0;
         idex_aluop   <= ALU_NOP;
         idex_alusel  <= SEL_NOP;
         idex_op1     <= '0;
         idex_op2     <= '0;
         idex_wr_addr <= '0;
         idex_wr_en   <= 1'b0;
         idex_invalid <= 1'b0;
         stall_cnt    <= '0;
      end else if (advance) begin
         if (hazard) begin
            idex_valid   <= 1'b0;
            idex_aluop   <= ALU_NOP;
            idex_alusel  <= SEL_NOP;
            idex_op1     <= '0;
            idex_op2     <= '0;
            idex_wr_addr <= '0;
            idex_wr_en   <= 1'b0;
            idex_invalid <= 1'b0;
            if (stall_cnt != '1) begin
               stall_cnt <= stall_cnt + 1'b1;
            end
         end else begin
            idex_valid   <= if_valid_in;
            idex_aluop   <= dec_aluop;
            idex_alusel  <= dec_alusel;
            idex_op1     <= dec_op1;
            idex_op2     <= dec_op2;
            idex_wr_addr <= dec_wr_addr;
            idex_wr_en   <= dec_wr_en;
            idex_invalid <= dec_invalid;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - scoreboard bench for id_stage_pipe with a mnemonic-level reference model
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        if_valid_in;
   logic [31:0] inst_in;
   logic [31:0] rf_rd_data1, rf_rd_data2;
   logic        ex_fwd_en, mem_fwd_en;
   logic [4:0]  ex_fwd_addr, mem_fwd_addr;
   logic [31:0] ex_fwd_data, mem_fwd_data;
   logic        ex_ready_in;

   logic        id_ready_out, rf_rd_en1, rf_rd_en2, idex_valid, idex_wr_en, idex_invalid;
   logic [4:0]  rf_rd_addr1, rf_rd_addr2, idex_wr_addr;
   logic [7:0]  idex_aluop;
   logic [2:0]  idex_alusel;
   logic [31:0] idex_op1, idex_op2;
   logic [15:0] stall_cnt;

   logic        d2_ready, d2_en1, d2_en2, d2_valid, d2_wr_en, d2_invalid;
   logic [4:0]  d2_addr1, d2_addr2, d2_wr_addr;
   logic [7:0]  d2_aluop;
   logic [2:0]  d2_alusel;
   logic [31:0] d2_op1, d2_op2;
   logic [1:0]  d2_stall_cnt;

   id_stage_pipe dut (
      .clk(clk), .rst_n(rst_n), .if_valid_in(if_valid_in), .inst_in(inst_in),
      .id_ready_out(id_ready_out), .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
      .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
      .ex_ready_in(ex_ready_in), .idex_valid(idex_valid), .idex_aluop(idex_aluop),
      .idex_alusel(idex_alusel), .idex_op1(idex_op1), .idex_op2(idex_op2),
      .idex_wr_addr(idex_wr_addr), .idex_wr_en(idex_wr_en), .idex_invalid(idex_invalid),
      .stall_cnt(stall_cnt)
   );

   id_stage_pipe #(.STALL_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .if_valid_in(if_valid_in), .inst_in(inst_in),
      .id_ready_out(d2_ready), .rf_rd_addr1(d2_addr1), .rf_rd_addr2(d2_addr2),
      .rf_rd_en1(d2_en1), .rf_rd_en2(d2_en2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
      .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
      .ex_ready_in(ex_ready_in), .idex_valid(d2_valid), .idex_aluop(d2_aluop),
      .idex_alusel(d2_alusel), .idex_op1(d2_op1), .idex_op2(d2_op2),
      .idex_wr_addr(d2_wr_addr), .idex_wr_en(d2_wr_en), .idex_invalid(d2_invalid),
      .stall_cnt(d2_stall_cnt)
   );

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  wr_addr;
      logic        wr_en;
      logic        invalid;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   // Model of what the ID/EX register holds after each edge.
   logic m_valid;
   logic [4:0] m_load_dest;
   int   m_stall;
   logic last_acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] src(input logic port2, input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (ex_fwd_en && ex_fwd_addr == r) return ex_fwd_data;
      if (mem_fwd_en && mem_fwd_addr == r) return mem_fwd_data;
      return port2 ? rf_rd_data2 : rf_rd_data1;
   endfunction

   function automatic exp_t model(input logic [31:0] i);
      exp_t e;
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd;
      op = i[31:26]; fn = i[5:0]; rs = i[25:21]; rt = i[20:16]; rd = i[15:11];
      e = '0;
      if (op == 6'h0D || op == 6'h0C || op == 6'h0E) begin
         e.aluop = (op == 6'h0D) ? 8'd1 : (op == 6'h0C) ? 8'd2 : 8'd3;
         e.alusel = 3'd1; e.op1 = src(1'b0, rs); e.op2 = {16'h0, i[15:0]}; e.wr_addr = rt;
      end else if (op == 6'h0F) begin
         e.aluop = 8'd1; e.alusel = 3'd1; e.op2 = {i[15:0], 16'h0}; e.wr_addr = rt;
      end else if (op == 6'h23) begin
         e.aluop = 8'd8; e.alusel = 3'd3; e.op1 = src(1'b0, rs);
         e.op2 = {{16{i[15]}}, i[15:0]}; e.wr_addr = rt;
      end else if (op == 6'h00 && (fn == 6'h25 || fn == 6'h24 || fn == 6'h26 || fn == 6'h27)) begin
         e.aluop = (fn == 6'h25) ? 8'd1 : (fn == 6'h24) ? 8'd2 : (fn == 6'h26) ? 8'd3 : 8'd4;
         e.alusel = 3'd1; e.op1 = src(1'b0, rs); e.op2 = src(1'b1, rt); e.wr_addr = rd;
      end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
         e.aluop = (fn == 6'h00) ? 8'd5 : (fn == 6'h02) ? 8'd6 : 8'd7;
         e.alusel = 3'd2; e.op1 = {27'd0, i[10:6]}; e.op2 = src(1'b1, rt); e.wr_addr = rd;
      end else begin
         e.invalid = 1'b1;
      end
      e.wr_en = !e.invalid && (e.wr_addr != 5'd0);
      return e;
   endfunction

   function automatic logic reads_reg(input logic [31:0] i, input logic [4:0] r);
      logic [5:0] op, fn;
      op = i[31:26]; fn = i[5:0];
      if (op == 6'h0D || op == 6'h0C || op == 6'h0E || op == 6'h23) return i[25:21] == r;
      if (op == 6'h00 && (fn == 6'h25 || fn == 6'h24 || fn == 6'h26 || fn == 6'h27))
         return (i[25:21] == r) || (i[20:16] == r);
      if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) return i[20:16] == r;
      return 1'b0;
   endfunction

   // Evaluate one cycle mid-period, then return just after the rising edge.
   task automatic run_cycle();
      logic adv, hz;
      exp_t e;
      @(negedge clk);
      last_acc = 1'b0;
      if (!rst_n) begin
         m_valid = 1'b0; m_load_dest = 5'd0; m_stall = 0;
         sb_q.delete();
      end else begin
         adv = !m_valid || ex_ready_in;
         hz  = m_valid && (m_load_dest != 5'd0) && if_valid_in && reads_reg(inst_in, m_load_dest);
         chk("id_ready_out", {31'd0, id_ready_out}, {31'd0, adv && !hz});
         chk("idex_valid", {31'd0, idex_valid}, {31'd0, m_valid});
         chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
         chk("stall_cnt_w2", {30'd0, d2_stall_cnt}, (m_stall > 3) ? 3 : m_stall);
         if (adv) begin
            if (hz) begin
               m_valid = 1'b0; m_load_dest = 5'd0; m_stall++;
            end else begin
               e = model(inst_in);
               m_valid = if_valid_in;
               m_load_dest = (if_valid_in && e.alusel == 3'd3 && e.wr_en) ? e.wr_addr : 5'd0;
               if (if_valid_in) begin
                  sb_q.push_back(e);
                  last_acc = 1'b1;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && idex_valid && ex_ready_in) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("aluop", {24'd0, idex_aluop}, {24'd0, e.aluop});
               chk("alusel", {29'd0, idex_alusel}, {29'd0, e.alusel});
               chk("op1", idex_op1, e.op1);
               chk("op2", idex_op2, e.op2);
               chk("wr_addr", {27'd0, idex_wr_addr}, {27'd0, e.wr_addr});
               chk("wr_en", {31'd0, idex_wr_en}, {31'd0, e.wr_en});
               chk("invalid", {31'd0, idex_invalid}, {31'd0, e.invalid});
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; if_valid_in = 1'b0;
      run_cycle();
      chk("rst_valid", {31'd0, idex_valid}, 32'd0);
      chk("rst_aluop", {24'd0, idex_aluop}, 32'd0);
      chk("rst_alusel", {29'd0, idex_alusel}, 32'd0);
      chk("rst_op1", idex_op1, 32'd0);
      chk("rst_op2", idex_op2, 32'd0);
      chk("rst_wr", {26'd0, idex_wr_addr, idex_wr_en}, 32'd0);
      chk("rst_invalid", {31'd0, idex_invalid}, 32'd0);
      chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
      chk("rst_stall_w2", {30'd0, d2_stall_cnt}, 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic v, input logic [31:0] i, input logic rdy);
      if_valid_in = v; inst_in = i; ex_ready_in = rdy;
      run_cycle();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [4:0] rs, rt, rd, sh;
      logic [15:0] imm;
      logic [5:0] lf[4], sf[3];
      lf = '{6'h25, 6'h24, 6'h26, 6'h27};
      sf = '{6'h00, 6'h02, 6'h03};
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      sh = 5'($urandom); imm = 16'($urandom);
      case ($urandom_range(0, 9))
         0: return {6'h0D, rs, rt, imm};
         1: return {6'h0C, rs, rt, imm};
         2: return {6'h0E, rs, rt, imm};
         3: return {6'h0F, rs, rt, imm};
         4, 5: return {6'h23, rs, rt, imm};
         6: return {6'h00, rs, rt, rd, sh, lf[$urandom_range(0, 3)]};
         7: return {6'h00, rs, rt, rd, sh, sf[$urandom_range(0, 2)]};
         8: return ($urandom_range(0, 1) == 1) ? {6'h3F, rs, rt, imm} : {6'h00, rs, rt, rd, sh, 6'h08};
         default: return 32'h0000_0000;
      endcase
   endfunction

   exp_t snap;

   initial begin
      rst_n = 1'b0; if_valid_in = 1'b0; inst_in = '0; ex_ready_in = 1'b0;
      rf_rd_data1 = '0; rf_rd_data2 = '0;
      ex_fwd_en = 1'b0; ex_fwd_addr = '0; ex_fwd_data = '0;
      mem_fwd_en = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
      m_valid = 1'b0; m_load_dest = '0; m_stall = 0; last_acc = 1'b0;
      do_reset();

      issue(1'b1, 32'h3401_1234, 1'b1);
      chk("ori_op2", idex_op2, 32'h0000_1234);
      chk("ori_aluop_wr", {idex_aluop, 3'd0, idex_wr_addr, 15'd0, idex_wr_en}, {8'd1, 3'd0, 5'd1, 15'd0, 1'b1});

      ex_fwd_en = 1'b1; ex_fwd_addr = 5'd1; ex_fwd_data = 32'hAA;
      mem_fwd_en = 1'b1; mem_fwd_addr = 5'd1; mem_fwd_data = 32'hBB;
      rf_rd_data1 = 32'hCC; rf_rd_data2 = 32'h22;
      issue(1'b1, 32'h0022_1825, 1'b1);
      chk("fwd_ex_op1", idex_op1, 32'hAA);
      ex_fwd_en = 1'b0;
      issue(1'b1, 32'h0022_1825, 1'b1);
      chk("fwd_mem_op1", idex_op1, 32'hBB);
      mem_fwd_en = 1'b0;

      issue(1'b1, 32'h8C24_0000, 1'b1);
      issue(1'b1, 32'h0082_2824, 1'b1);
      chk("lu_bubble", {31'd0, idex_valid}, 32'd0);
      issue(1'b1, 32'h0082_2824, 1'b1);
      chk("lu_stall1", {16'd0, stall_cnt}, 32'd1);

      issue(1'b1, 32'h3405_0055, 1'b1);
      snap = {idex_aluop, idex_alusel, idex_op1, idex_op2, idex_wr_addr, idex_wr_en, idex_invalid};
      for (int k = 0; k < 3; k++) begin
         issue(1'b1, 32'h3406_0066, 1'b0);
         chk("hold_fields", 32'(({idex_aluop, idex_alusel, idex_op1, idex_op2, idex_wr_addr,
                                  idex_wr_en, idex_invalid} == snap) && idex_valid), 32'd1);
      end
      do_reset();

      issue(1'b1, 32'hFC00_0000, 1'b1);
      chk("invalid_flag", {30'd0, idex_invalid, idex_wr_en}, 32'd2);

      for (int k = 0; k < 5; k++) begin
         issue(1'b1, 32'h8C24_0000, 1'b1);
         issue(1'b1, 32'h0082_2824, 1'b1);
         issue(1'b1, 32'h0082_2824, 1'b1);
      end
      chk("sat_w2", {30'd0, d2_stall_cnt}, 32'd3);
      chk("stall_5", {16'd0, stall_cnt}, 32'd5);

      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) do_reset();
         rf_rd_data1 = $urandom; rf_rd_data2 = $urandom;
         ex_fwd_en = 1'($urandom); ex_fwd_addr = 5'($urandom_range(0, 7)); ex_fwd_data = $urandom;
         mem_fwd_en = 1'($urandom); mem_fwd_addr = 5'($urandom_range(0, 7)); mem_fwd_data = $urandom;
         if (!(if_valid_in && !last_acc)) begin
            if_valid_in = ($urandom_range(0, 9) < 8);
            inst_in = rand_inst();
         end
         ex_ready_in = ($urandom_range(0, 3) != 0);
         run_cycle();
      end

      for (int k = 0; k < 4; k++) issue(1'b0, 32'h0, 1'b1);
      chk("queue_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
